// File: rtl/md5_pkg.sv
// Shared constants and types for the MD5 block padder.
package md5_pkg;
   localparam int          MD5_BLK_W   = 512;
   localparam int          MD5_WORDS   = 16;
   localparam int          MD5_LEN_POS = 56;
   localparam logic [31:0] MD5_IV_A    = 32'h67452301;
   localparam logic [31:0] MD5_IV_B    = 32'hefcdab89;
   localparam logic [31:0] MD5_IV_C    = 32'h98badcfe;
   localparam logic [31:0] MD5_IV_D    = 32'h10325476;

   typedef enum logic {S_FILL, S_FULL} state_t;
   typedef logic [MD5_WORDS-1:0][31:0] blk_t;
endpackage

// File: rtl/md5_pad_insert.sv
// Zeroes the unused bytes of a final message word and places the 0x80 marker.
module md5_pad_insert (
   input  logic [31:0] word,
   input  logic [2:0]  nbytes,
   output logic [31:0] padded,
   output logic        spill
);
   logic [2:0] nb;

   assign nb    = (nbytes > 3'd4) ? 3'd4 : nbytes;
   assign spill = (nb == 3'd4);

   always_comb begin
      padded = '0;
      for (int j = 0; j < 4; j++) begin
         if (3'(j) < nb)
            padded[8*j +: 8] = word[8*j +: 8];
         else if (3'(j) == nb)
            padded[8*j +: 8] = 8'h80;
      end
   end
endmodule

// File: rtl/md5_block_padder.sv
// Packs a 32-bit little-endian word stream into RFC 1321 padded 512-bit blocks,
// emitting a second length-only block when the tail does not leave room for the length.
module md5_block_padder
   import md5_pkg::*;
#(
   parameter logic [31:0] IV_A = MD5_IV_A,
   parameter logic [31:0] IV_B = MD5_IV_B,
   parameter logic [31:0] IV_C = MD5_IV_C,
   parameter logic [31:0] IV_D = MD5_IV_D
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          in_data,
   input  logic                 in_valid,
   input  logic                 in_last,
   input  logic [2:0]           in_bytes,
   output logic                 in_ready,
   output logic [MD5_BLK_W-1:0] wb_out,
   output logic [31:0]          a_out,
   output logic [31:0]          b_out,
   output logic [31:0]          c_out,
   output logic [31:0]          d_out,
   output logic                 blk_first,
   output logic                 blk_last,
   output logic                 blk_valid,
   input  logic                 blk_ready
);
   state_t      state, state_n;
   blk_t        buf_q, wb_q, blk_n, pad2_blk;
   logic [3:0]  widx;
   logic [60:0] bytes_q, bytes_tot;
   logic [63:0] len_q, len_n;
   logic        first_pending, pad2, need80;
   logic [31:0] pad_word, cur_word;
   logic        spill, acc, seal, xfer, short_msg;
   logic [2:0]  nb;
   logic [6:0]  pos;

   md5_pad_insert u_pad (
      .word   (in_data),
      .nbytes (in_bytes),
      .padded (pad_word),
      .spill  (spill)
   );

   assign in_ready  = (state == S_FILL) & rst_n;
   assign acc       = in_valid & in_ready;
   assign seal      = acc & (in_last | (widx == 4'd15));
   assign xfer      = (state == S_FULL) & blk_ready;
   assign nb        = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
   // pos is where the 0x80 byte lands inside the current block
   assign pos       = {1'b0, widx, 2'b00} + {4'b0, nb};
   assign short_msg = pos < 7'(MD5_LEN_POS);
   assign bytes_tot = bytes_q + {58'b0, nb};
   assign len_n     = {bytes_tot, 3'b000};
   assign cur_word  = in_last ? pad_word : in_data;

   always_comb begin
      blk_n = '0;
      for (int i = 0; i < MD5_WORDS; i++) begin
         if (4'(i) < widx)
            blk_n[i] = buf_q[i];
         else if (4'(i) == widx)
            blk_n[i] = cur_word;
         else if (in_last && spill && (5'(i) == {1'b0, widx} + 5'd1))
            blk_n[i] = 32'h0000_0080;
      end
      if (in_last && short_msg) begin
         blk_n[14] = len_n[31:0];
         blk_n[15] = len_n[63:32];
      end
   end

   always_comb begin
      pad2_blk     = '0;
      pad2_blk[0]  = need80 ? 32'h0000_0080 : 32'h0;
      pad2_blk[14] = len_q[31:0];
      pad2_blk[15] = len_q[63:32];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_FILL;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_FILL:  if (seal) state_n = S_FULL;
         S_FULL:  if (xfer && !pad2) state_n = S_FILL;
         default: state_n = S_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q         <= '0;
         wb_q          <= '0;
         widx          <= '0;
         bytes_q       <= '0;
         len_q         <= '0;
         first_pending <= 1'b1;
         pad2          <= 1'b0;
         need80        <= 1'b0;
         blk_first     <= 1'b0;
         blk_last      <= 1'b0;
         blk_valid     <= 1'b0;
      end else begin
         if (acc) begin
            if (!in_last) begin
               buf_q[widx] <= in_data;
               bytes_q     <= bytes_q + 61'd4;
               widx        <= widx + 4'd1;
            end else begin
               // message done: length is frozen for a possible trailing block
               bytes_q       <= '0;
               widx          <= '0;
               len_q         <= len_n;
               pad2          <= !short_msg;
               need80        <= spill && (widx == 4'd15);
               first_pending <= 1'b1;
            end
            if (seal) begin
               wb_q      <= blk_n;
               blk_valid <= 1'b1;
               blk_first <= first_pending;
               blk_last  <= in_last && short_msg;
               if (!in_last) first_pending <= 1'b0;
            end
         end
         if (xfer) begin
            if (pad2) begin
               wb_q      <= pad2_blk;
               blk_first <= 1'b0;
               blk_last  <= 1'b1;
               pad2      <= 1'b0;
            end else begin
               blk_valid <= 1'b0;
            end
         end
      end
   end

   assign wb_out = wb_q;
   assign a_out  = IV_A;
   assign b_out  = IV_B;
   assign c_out  = IV_C;
   assign d_out  = IV_D;
endmodule
